// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt controller: msip/mtime/mtimecmp MMIO block with a
// one-wait-state bus, prescaled 64-bit timer and post-redirect holdoff.
module interrupt_ctrl #(
   parameter int unsigned TICK_DIV = 1,
   parameter int unsigned HOLDOFF  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_sel,
   input  logic        bus_we,
   input  logic [4:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   input  logic        irq_taken,
   output logic        interrupt,
   output logic [31:0] irq_code
);

   typedef enum logic {
      S_IDLE,
      S_RESP
   } state_t;

   localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);
   localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

   state_t      state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic [7:0]  presc_q, presc_d;
   logic [3:0]  hold_q, hold_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic [31:0] code_q, code_d;

   logic accept;
   logic aligned;
   logic timer_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         presc_q    <= '0;
         hold_q     <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         presc_q    <= presc_d;
         hold_q     <= hold_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         code_q     <= code_d;
      end
   end

   // Bus FSM: a request is taken only in IDLE, RESP always returns to IDLE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus_sel) begin
               state_d = S_RESP;
               accept  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign aligned = (bus_addr[1:0] == 2'b00);

   // Read data is captured from the pre-write register values at the accept edge.
   always_comb begin
      rdata_d = rdata_q;
      if (accept) begin
         rdata_d = '0;
         if (aligned) begin
            case (bus_addr[4:2])
               3'd0:    rdata_d = {31'b0, msip_q};
               3'd1:    rdata_d = mtimecmp_q[31:0];
               3'd2:    rdata_d = mtimecmp_q[63:32];
               3'd3:    rdata_d = mtime_q[31:0];
               3'd4:    rdata_d = mtime_q[63:32];
               default: rdata_d = '0;
            endcase
         end
      end
   end

   // A bus write to either mtime half overrides the tick and restarts the prescaler.
   always_comb begin
      msip_d     = msip_q;
      mtimecmp_d = mtimecmp_q;
      mtime_d    = mtime_q;
      presc_d    = presc_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         mtime_d = mtime_q + 64'd1;
      end else begin
         presc_d = presc_q + 8'd1;
      end
      if (accept && bus_we && aligned) begin
         case (bus_addr[4:2])
            3'd0: msip_d = bus_wdata[0];
            3'd1: mtimecmp_d[31:0]  = bus_wdata;
            3'd2: mtimecmp_d[63:32] = bus_wdata;
            3'd3: begin
               mtime_d = {mtime_q[63:32], bus_wdata};
               presc_d = '0;
            end
            3'd4: begin
               mtime_d = {bus_wdata, mtime_q[31:0]};
               presc_d = '0;
            end
            default: ;
         endcase
      end
   end

   assign timer_pending = (mtime_q >= mtimecmp_q);

   always_comb begin
      hold_d = hold_q;
      if (irq_taken) begin
         hold_d = HOLD_LOAD;
      end else if (hold_q != '0) begin
         hold_d = hold_q - 4'd1;
      end
      irq_d  = 1'b0;
      code_d = '0;
      if (hold_q == '0) begin
         if (msip_q) begin
            irq_d  = 1'b1;
            code_d = 32'd3;
         end else if (timer_pending) begin
            irq_d  = 1'b1;
            code_d = 32'd7;
         end
      end
   end

   assign bus_ready = (state_q == S_RESP);
   assign bus_rdata = rdata_q;
   assign interrupt = irq_q;
   assign irq_code  = code_q;

endmodule
